instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream fetch stage for the single-cycle core: owns the PC, fetches from instruction memory via req/rdy,
//  presents Instr (Opcode/Funct3/Funct7 fields) to the control unit, then applies next-PC on EN_PC/Branch/Jump.
//  Freezes in HALT on undefined instruction, misaligned target or fetch timeout.
// PARAMETERS
//  XLEN          32   data/address width
//  RESET_VECTOR  0    PC value after reset
//  MAX_WAIT      15   max cycles waiting on IMEM_Rdy before fetch error (>=1)
// PORTS
//  CLK            in   1     core clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  IMEM_Req       out  1     fetch request, held until IMEM_Rdy
//  IMEM_Addr      out  XLEN  fetch address (= PC while IMEM_Req)
//  IMEM_Rdy       in   1     IMEM_Data valid this cycle
//  IMEM_Data      in   32    fetched instruction word
//  Instr          out  32    registered instruction to control unit/decoders
//  Instr_Valid    out  1     high exactly during EXEC
//  PC             out  XLEN  current PC
//  PC_Plus4       out  XLEN  PC+4 (JAL/JALR link value)
//  EN_PC          in   1     from control unit: commit next PC
//  Branch         in   1     conditional-branch instruction
//  Branch_Taken   in   1     ALU compare result
//  Jump           in   1     JAL or JALR
//  Jalr           in   1     jump target is register based
//  Imm_Ext        in   XLEN  sign-extended immediate
//  ALU_Result     in   XLEN  rs1+imm for JALR
//  undef_instr    in   1     from control unit
//  Halted         out  1     core stopped
//  Halt_Cause     out  2     00 none, 01 undef, 10 misaligned target, 11 fetch timeout
// BEHAVIOUR
//  Reset (async): state=FETCH, PC=RESET_VECTOR, Instr=32'h0000_0013 (NOP), Instr_Valid=0, Halted=0,
//   Halt_Cause=00, wait counter=0, IMEM_Req=0 during reset; IMEM_Req=1 first cycle after deassert.
//  States FETCH -> EXEC -> FETCH; any -> HALT (terminal until reset).
//  FETCH: IMEM_Req=1, IMEM_Addr=PC. IMEM_Rdy=1 -> latch IMEM_Data into Instr, cnt=0, go EXEC.
//   Else cnt++; cnt==MAX_WAIT with no Rdy -> HALT, cause 11. Rdy on that same cycle wins (no error).
//  EXEC (exactly one cycle): Instr_Valid=1, IMEM_Req=0; control inputs sampled at end of cycle.
//   Priority: undef_instr -> HALT cause 01, PC unchanged.
//   Else EN_PC=0 -> PC held, go FETCH (refetch same PC; replay/stall).
//   Else target: Jump&Jalr -> {ALU_Result[XLEN-1:1],1'b0}; Jump&!Jalr -> PC+Imm_Ext;
//    Branch&Branch_Taken -> PC+Imm_Ext; otherwise PC+4. Jump has priority over Branch.
//   target[1:0]!=0 -> HALT cause 10, PC unchanged; else PC<=target, go FETCH.
//  Arithmetic modulo 2^XLEN; PC wraps silently at top of space. Latency: 2 cycles/instr with zero-wait IMEM.
//  HALT: Halted=1, IMEM_Req=0, Instr_Valid=0, PC/Instr/Halt_Cause frozen; only rst_n exits.
//  Reset mid-fetch: request dropped immediately; late IMEM_Rdy after reset ignored unless in FETCH.
//  Halt_Cause only written on HALT entry; first cause wins.
// STRUCTURE
//  Shared package: state encodings (FETCH/EXEC/HALT), Halt_Cause codes, NOP constant 32'h0000_0013.
//  One natural sub-module: next_pc_gen (combinational target select + misalign flag); FSM/regs in top.
// TESTING
//  1 Reset, IMEM zero-wait, sequential ADDIs at 0x0/0x4 -> IMEM_Addr 0x0,0x4,0x8; Instr_Valid every 2nd cycle.
//  2 EXEC PC=0x100, Branch=1, Branch_Taken=1, Imm_Ext=-8 -> next IMEM_Addr 0xF8; Taken=0 -> 0x104.
//  3 JALR: ALU_Result=0x203 -> PC=0x202 -> HALT cause 10 (misaligned), PC stays; JAL Imm=0x40 @0x10 -> 0x50.
//  4 undef_instr=1 in EXEC at PC=0x20 -> Halted=1, Halt_Cause=01, PC=0x20, IMEM_Req=0 forever.
//  5 IMEM_Rdy withheld: Rdy on MAX_WAIT cycle -> normal EXEC; withheld MAX_WAIT cycles -> Halt_Cause=11.
//  6 rst_n pulsed mid-FETCH/in HALT -> PC=RESET_VECTOR, Halted=0 asynchronously; EN_PC=0 refetches same PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encodings,
// halt cause codes, the reset NOP and the control-flow bundle for next-PC selection.
package instr_fetch_unit_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_UNDEF    = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic branch;
    logic branch_taken;
    logic jump;
    logic jalr;
  } flow_ctrl_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch port: request/address from the fetch unit,
// ready/data back from the memory.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            IMEM_Req;
  logic [XLEN-1:0] IMEM_Addr;
  logic            IMEM_Rdy;
  logic [31:0]     IMEM_Data;

  modport master (
    output IMEM_Req,
    output IMEM_Addr,
    input  IMEM_Rdy,
    input  IMEM_Data
  );

  modport slave (
    input  IMEM_Req,
    input  IMEM_Addr,
    output IMEM_Rdy,
    output IMEM_Data
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// Combinational next-PC selection: JALR > JAL > taken branch > PC+4,
// plus a flag when the chosen target is not word aligned.
module instr_fetch_unit_next_pc_gen
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  flow_ctrl_t      flow,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  assign pc_plus4 = pc + XLEN'(4);

  // NOTE: target gets a default before any branch so this block can never infer a latch.
  always_comb begin
    target = pc_plus4;
    if (flow.jump && flow.jalr) begin
      target = alu_result & ~XLEN'(1);
    end else if (flow.jump || (flow.branch && flow.branch_taken)) begin
      target = pc + imm_ext;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle core: owns the PC, runs FETCH -> EXEC -> FETCH,
// and freezes in HALT on an undefined instruction, misaligned target or fetch timeout.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              MAX_WAIT     = 15
) (
  input  logic                CLK,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         Instr,
  output logic                Instr_Valid,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     PC_Plus4,
  input  logic                EN_PC,
  input  logic                Branch,
  input  logic                Branch_Taken,
  input  logic                Jump,
  input  logic                Jalr,
  input  logic [XLEN-1:0]     Imm_Ext,
  input  logic [XLEN-1:0]     ALU_Result,
  input  logic                undef_instr,
  output logic                Halted,
  output logic [1:0]          Halt_Cause
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [1:0]      state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] target;
  logic            misaligned;
  flow_ctrl_t      flow;

  assign flow = '{branch: Branch, branch_taken: Branch_Taken, jump: Jump, jalr: Jalr};

  instr_fetch_unit_next_pc_gen #(
    .XLEN(XLEN)
  ) u_next_pc_gen (
    .pc         (PC),
    .imm_ext    (Imm_Ext),
    .alu_result (ALU_Result),
    .flow       (flow),
    .pc_plus4   (PC_Plus4),
    .target     (target),
    .misaligned (misaligned)
  );

  // The request is gated by rst_n so it drops the instant reset asserts mid-fetch.
  assign imem.IMEM_Req  = rst_n && (state == ST_FETCH);
  assign imem.IMEM_Addr = PC;
  assign Instr_Valid    = (state == ST_EXEC);
  assign Halted         = (state == ST_HALT);

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      PC         <= RESET_VECTOR;
      Instr      <= NOP_INSTR;
      Halt_Cause <= CAUSE_NONE;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          // At most MAX_WAIT fetch cycles; Rdy on the last of them still wins.
          if (imem.IMEM_Rdy) begin
            Instr    <= imem.IMEM_Data;
            wait_cnt <= '0;
            state    <= ST_EXEC;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            state      <= ST_HALT;
            Halt_Cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_EXEC: begin
          if (undef_instr) begin
            state      <= ST_HALT;
            Halt_Cause <= CAUSE_UNDEF;
          end else if (!EN_PC) begin
            state <= ST_FETCH;
          end else if (misaligned) begin
            state      <= ST_HALT;
            Halt_Cause <= CAUSE_MISALIGN;
          end else begin
            PC    <= target;
            state <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_instr_fetch_unit;

  localparam int XLEN = 32;
  localparam int MW   = 15;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.XLEN(XLEN)) imem ();

  logic [31:0]     Instr;
  logic            Instr_Valid;
  logic [XLEN-1:0] PC, PC_Plus4;
  logic            EN_PC, Branch, Branch_Taken, Jump, Jalr, undef_instr;
  logic [XLEN-1:0] Imm_Ext, ALU_Result;
  logic            Halted;
  logic [1:0]      Halt_Cause;

  instr_fetch_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h0), .MAX_WAIT(MW)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .imem(imem),
    .Instr(Instr), .Instr_Valid(Instr_Valid), .PC(PC), .PC_Plus4(PC_Plus4),
    .EN_PC(EN_PC), .Branch(Branch), .Branch_Taken(Branch_Taken), .Jump(Jump), .Jalr(Jalr),
    .Imm_Ext(Imm_Ext), .ALU_Result(ALU_Result), .undef_instr(undef_instr),
    .Halted(Halted), .Halt_Cause(Halt_Cause)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: architectural view of the fetch unit.
  logic [31:0] m_pc, m_instr;
  logic        m_halted;
  logic [1:0]  m_cause;

  task automatic drive_idle();
    EN_PC = 1'b0; Branch = 1'b0; Branch_Taken = 1'b0; Jump = 1'b0; Jalr = 1'b0;
    undef_instr = 1'b0; Imm_Ext = '0; ALU_Result = '0;
    imem.IMEM_Rdy = 1'b0; imem.IMEM_Data = '0;
  endtask

  // Asserts reset between edges, checks the async effect, releases before the next posedge.
  task automatic do_reset(input string tag);
    drive_idle();
    @(negedge CLK);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem.IMEM_Req, Instr_Valid, Halted, Halt_Cause, PC, Instr} !==
        {1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0000_0013}) begin
      miscompares++;
      $display("FAIL %s in-reset: req=%b valid=%b halted=%b cause=%b pc=%h instr=%h, want 0 0 0 00 00000000 00000013",
               tag, imem.IMEM_Req, Instr_Valid, Halted, Halt_Cause, PC, Instr);
    end
    #1 rst_n = 1'b1;
    m_pc = 32'h0; m_instr = 32'h0000_0013; m_halted = 1'b0; m_cause = 2'b00;
    #1;
    vectors++;
    if ({imem.IMEM_Req, imem.IMEM_Addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL %s post-reset req: req=%b addr=%h, want 1 00000000", tag, imem.IMEM_Req, imem.IMEM_Addr);
    end
  endtask

  // One complete instruction: fetch with `delay` wait cycles, then EXEC with the given controls.
  task automatic do_instr(input string tag, input logic [31:0] word, input int delay,
                          input logic en, input logic br, input logic tk, input logic jmp,
                          input logic jr, input logic und, input logic [31:0] imm,
                          input logic [31:0] alu);
    logic [31:0] tgt;
    for (int k = 0; k < MW; k++) begin
      vectors++;
      if ({imem.IMEM_Req, imem.IMEM_Addr, Instr_Valid, Halted} !== {1'b1, m_pc, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL %s fetch[%0d]: req=%b addr=%h valid=%b halted=%b, want 1 %h 0 0",
                 tag, k, imem.IMEM_Req, imem.IMEM_Addr, Instr_Valid, Halted, m_pc);
      end
      imem.IMEM_Rdy  = (k == delay);
      imem.IMEM_Data = (k == delay) ? word : $urandom;
      @(negedge CLK);
      if (k == delay) break;
    end
    imem.IMEM_Rdy = 1'b0;
    if (delay >= MW) begin
      m_halted = 1'b1; m_cause = 2'b11;
    end else begin
      m_instr = word;
      vectors++;
      if ({Instr_Valid, imem.IMEM_Req, Halted, Instr, PC, PC_Plus4} !==
          {1'b1, 1'b0, 1'b0, word, m_pc, m_pc + 32'd4}) begin
        miscompares++;
        $display("FAIL %s exec: valid=%b req=%b halted=%b instr=%h pc=%h pc4=%h, want 1 0 0 %h %h %h",
                 tag, Instr_Valid, imem.IMEM_Req, Halted, Instr, PC, PC_Plus4, word, m_pc, m_pc + 32'd4);
      end
      EN_PC = en; Branch = br; Branch_Taken = tk; Jump = jmp; Jalr = jr;
      undef_instr = und; Imm_Ext = imm; ALU_Result = alu;
      if (und) begin
        m_halted = 1'b1; m_cause = 2'b01;
      end else if (en) begin
        if (jmp && jr)             tgt = alu & 32'hFFFF_FFFE;
        else if (jmp || (br && tk)) tgt = m_pc + imm;
        else                        tgt = m_pc + 32'd4;
        if (tgt % 4 != 0) begin
          m_halted = 1'b1; m_cause = 2'b10;
        end else begin
          m_pc = tgt;
        end
      end
      @(negedge CLK);
      drive_idle();
    end
    vectors++;
    if ({Halted, Halt_Cause, PC, Instr_Valid, imem.IMEM_Req, Instr} !==
        {m_halted, m_cause, m_pc, 1'b0, ~m_halted, m_instr}) begin
      miscompares++;
      $display("FAIL %s after: halted=%b cause=%b pc=%h valid=%b req=%b instr=%h, want %b %b %h 0 %b %h",
               tag, Halted, Halt_Cause, PC, Instr_Valid, imem.IMEM_Req, Instr,
               m_halted, m_cause, m_pc, ~m_halted, m_instr);
    end
  endtask

  // While halted, random activity on every input must change nothing.
  task automatic hold_halt(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      EN_PC = $urandom; Branch = $urandom; Branch_Taken = $urandom; Jump = $urandom;
      Jalr = $urandom; undef_instr = $urandom; Imm_Ext = $urandom; ALU_Result = $urandom;
      imem.IMEM_Rdy = $urandom; imem.IMEM_Data = $urandom;
      @(negedge CLK);
      vectors++;
      if ({Halted, Halt_Cause, PC, Instr_Valid, imem.IMEM_Req, Instr} !==
          {1'b1, m_cause, m_pc, 1'b0, 1'b0, m_instr}) begin
        miscompares++;
        $display("FAIL %s hold[%0d]: halted=%b cause=%b pc=%h valid=%b req=%b instr=%h, want 1 %b %h 0 0 %h",
                 tag, i, Halted, Halt_Cause, PC, Instr_Valid, imem.IMEM_Req, Instr, m_cause, m_pc, m_instr);
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_sequential();
    do_instr("seq0", 32'h0010_0093, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_instr("seq1", 32'h0020_0113, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_instr("seq2", 32'h0030_0193, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_branch();
    do_reset("branch_rst");
    do_instr("jal_to_100", 32'h1000_006F, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
    do_instr("beq_taken",  32'hFE00_0CE3, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    do_instr("jal_back",   32'h0080_006F, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    do_instr("beq_not",    32'hFE00_0CE3, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    do_instr("at_104",     32'h0000_0013, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_jump();
    do_reset("jump_rst");
    do_instr("jal_to_10",  32'h0100_006F, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    do_instr("jal_over_br", 32'h0400_006F, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    do_instr("jalr_align", 32'h0000_8067, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h61);
    do_instr("jalr_mis",   32'h0000_8067, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h203);
    hold_halt("jalr_mis", 5);
  endtask

  task automatic test_undef();
    do_reset("undef_rst");
    do_instr("jal_to_20", 32'h0200_006F, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    do_instr("undef",     32'hFFFF_FFFF, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    hold_halt("undef", 8);
    do_reset("reset_in_halt");
  endtask

  task automatic test_timeout();
    do_instr("rdy_last", 32'h0010_0093, MW - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_instr("timeout",  32'h0020_0113, MW,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    hold_halt("timeout", 6);
  endtask

  task automatic test_reset_mid_fetch();
    do_reset("mid_rst0");
    imem.IMEM_Rdy = 1'b0;
    repeat (5) @(negedge CLK);
    do_reset("mid_fetch");
    do_instr("post_mid", 32'h0050_0293, MW - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_stall();
    do_instr("stall",   32'h0060_0313, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    do_instr("refetch", 32'h0060_0313, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] imm;
    int dly;
    do_reset("rand_rst");
    for (int i = 0; i < 80; i++) begin
      if (m_halted) do_reset("rand_rerst");
      imm = ($urandom % 16 == 0) ? $urandom : (($urandom & 32'h0000_0FFC) - 32'h800);
      dly = ($urandom % 25 == 0) ? MW : int'($urandom_range(0, 3));
      do_instr("rand", $urandom, dly, ($urandom % 8) != 0, 1'($urandom), 1'($urandom),
               ($urandom % 4) == 0, 1'($urandom), ($urandom % 20) == 0, imm, $urandom);
    end
  endtask

  initial begin
    drive_idle();
    m_pc = 32'h0; m_instr = 32'h0000_0013; m_halted = 1'b0; m_cause = 2'b00;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_undef();
    test_timeout();
    test_reset_mid_fetch();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
